mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage directly downstream of EX. Consumes EX's memory flags, address (EX result),
//  store data and writeback info. Runs a req/ack transaction on the data RAM, steers and
//  extends byte lanes, and stalls the pipeline while the RAM is busy.
//  Registers the final result into the MEM/WB boundary.
// PARAMETERS
//  DATA_W       32   data / address width
//  RAM_TIMEOUT  255  max WAIT cycles without ram_ack before bus_error (>=1)
// PORTS
//  clk                  in   1   single clock, rising edge
//  rst_n                in   1   asynchronous, active-low reset
//  flush                in   1   kill instruction currently in MEM (exception/redirect)
//  mem_read_flag_in     in   1   load
//  mem_write_flag_in    in   1   store (read and write never both 1)
//  mem_sign_flag_in     in   1   1 = sign-extend load, 0 = zero-extend
//  mem_sel_in           in   4   size: 4'b0001 byte, 4'b0011 half, 4'b1111 word (unshifted)
//  mem_write_data_in    in   32  store data, right-justified
//  result_in            in   32  EX result; memory address when read/write flag set
//  reg_write_en_in      in   1   writeback enable from EX
//  reg_write_addr_in    in   5   destination register
//  current_pc_addr_in   in   32  PC of instruction
//  ram_req              out  1   registered; held high until ack or timeout
//  ram_we               out  1   1 = write
//  ram_addr             out  32  word-aligned address ({addr[31:2],2'b00})
//  ram_be               out  4   byte enables, little-endian
//  ram_wdata            out  32  lane-steered store data
//  ram_ack              in   1   one-cycle completion; ram_rdata valid with it
//  ram_rdata            in   32  read word
//  stall_request        out  1   combinational; freezes PC..EX while high
//  mem_load_flag        out  1   = mem_read_flag_in; for ID load-use hazard detection
//  result_out           out  32  registered writeback data
//  reg_write_en_out     out  1   registered
//  reg_write_addr_out   out  5   registered
//  current_pc_addr_out  out  32  registered
//  addr_error           out  1   registered one-cycle pulse: misaligned access
//  bus_error            out  1   registered one-cycle pulse: RAM timeout
// BEHAVIOUR
//  Reset: state IDLE; counter 0; every registered output 0; ram_req 0.
//  FSM: IDLE, WAIT.
//   IDLE, no mem op: result/reg info loaded into WB regs at the next edge (latency 1), no stall.
//   IDLE, aligned mem op: stall_request=1.
//     Next edge: go to WAIT, drive ram_req/we/addr/be/wdata, clear counter.
//   WAIT: stall_request=1 until the ram_ack cycle (stall=0 in that cycle).
//     At that edge the WB regs load and the state returns to IDLE; the counter increments each non-ack cycle.
//   WAIT, counter==RAM_TIMEOUT-1, no ack: drop ram_req, pulse bus_error, reg_write_en_out=0, go IDLE.
//  EX inputs are held stable by the stall for the whole transaction; they are sampled from the live inputs.
//  Alignment: half needs addr[0]==0; word needs addr[1:0]==0.
//   Misaligned: no RAM access, no stall, addr_error pulse, reg_write_en_out=0.
//  Lanes: ram_be = mem_sel_in << addr[1:0].
//   ram_wdata replicates the byte (x4) or half (x2); word passes through.
//  Load: extract lane at addr[1:0], sign/zero extend per mem_sign_flag_in, to result_out.
//  Store: reg_write_en_out forced 0. Non-mem op: result_out = result_in.
//  flush in IDLE: no RAM access issued; WB regs load with reg_write_en_out=0.
//  flush in WAIT: the transaction is not cancelled; set flush_pending and wait for ack/timeout.
//   Then load WB regs with reg_write_en_out=0; flush_pending clears on return to IDLE.
//  ram_ack while IDLE (late ack after timeout): ignored.
//  Reset mid-WAIT: immediate return to IDLE, ram_req 0; RAM must tolerate abandoned request.
// STRUCTURE
//  Shared defines (bus.v): MEM_SEL_BYTE/HALF/WORD, MEM_SEL_BUS, state encodings MEM_ST_IDLE/WAIT.
//  Sub-module mem_align (combinational):
//   - store: be/wdata steering
//   - load: extraction/extension
//   - misalign detect
//  mem_stage holds the FSM, timeout counter and WB regs.
// TESTING
//  Non-mem op, result_in=32'h1234 -> next cycle result_out=32'h1234, stall never high.
//  lb, addr 32'h1003, sign=1, rdata=32'h80xxxxxx, ack after 2 WAIT cycles
//   -> be=4'b1000, stall 3 cycles, result_out=32'hFFFFFF80.
//  sh, addr 32'h2002, data 32'h0000ABCD
//   -> be=4'b1100, wdata=32'hABCDABCD, we=1, reg_write_en_out=0.
//  lw, addr 32'h3001 -> no ram_req, addr_error pulse 1 cycle, reg_write_en_out=0.
//  lw, no ack for RAM_TIMEOUT cycles -> req drops, bus_error pulse.
//   Later stray ack ignored; next op works.
//  lw in WAIT, flush pulsed -> ack still consumed, reg_write_en_out=0.
//   Also: rst_n low mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings,
// FSM state encoding and the alignment rule.
package mem_stage_pkg;

    localparam int MEM_SEL_BUS = 4;

    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_HALF = 4'b0011;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_WORD = 4'b1111;

    typedef enum logic {
        MEM_ST_IDLE = 1'b0,
        MEM_ST_WAIT = 1'b1
    } mem_state_e;

    // Halfwords must sit on an even address, words on a multiple of four.
    function automatic logic is_misaligned(input logic [MEM_SEL_BUS-1:0] sel,
                                           input logic [1:0]             off);
        logic bad;
        bad = 1'b0;
        if (sel == MEM_SEL_HALF) bad = off[0];
        if (sel == MEM_SEL_WORD) bad = (off != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-RAM request/acknowledge bus between the MEM stage (master) and the RAM (slave).
interface mem_stage_if #(parameter int DATA_W = 32);
    import mem_stage_pkg::*;

    logic                   ram_req;
    logic                   ram_we;
    logic [DATA_W-1:0]      ram_addr;
    logic [MEM_SEL_BUS-1:0] ram_be;
    logic [DATA_W-1:0]      ram_wdata;
    logic                   ram_ack;
    logic [DATA_W-1:0]      ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_be, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_be, ram_wdata,
        output ram_ack, ram_rdata
    );

endinterface

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: store steering, load extraction/extension
// and misalignment detection.
module mem_stage_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [MEM_SEL_BUS-1:0] sel_i,
    input  logic [1:0]             off_i,
    input  logic                   sign_i,
    input  logic [DATA_W-1:0]      store_data_i,
    input  logic [DATA_W-1:0]      rdata_i,
    output logic [MEM_SEL_BUS-1:0] be_o,
    output logic [DATA_W-1:0]      wdata_o,
    output logic [DATA_W-1:0]      load_data_o,
    output logic                   misalign_o
);

    logic        [DATA_W-1:0] shifted;
    logic signed [7:0]        byte_s;
    logic signed [15:0]       half_s;
    logic signed [DATA_W-1:0] byte_sx;
    logic signed [DATA_W-1:0] half_sx;

    assign shifted = rdata_i >> {off_i, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];
    assign byte_sx = byte_s;
    assign half_sx = half_s;

    assign misalign_o = is_misaligned(sel_i, off_i);

    // Shift enables onto the addressed lanes and replicate narrow store data across the word.
    always_comb begin
        be_o = sel_i << off_i;
        case (sel_i)
            MEM_SEL_BYTE: wdata_o = {4{store_data_i[7:0]}};
            MEM_SEL_HALF: wdata_o = {2{store_data_i[15:0]}};
            default:      wdata_o = store_data_i;
        endcase
    end

    // Pull the addressed lane down to bit 0 and extend it to full width.
    always_comb begin
        case (sel_i)
            MEM_SEL_BYTE: load_data_o = sign_i ? byte_sx : {{(DATA_W-8){1'b0}}, shifted[7:0]};
            MEM_SEL_HALF: load_data_o = sign_i ? half_sx : {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default:      load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-RAM transactions, stalls the front of the
// pipeline while the RAM is busy, and registers the MEM/WB boundary.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int RAM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   mem_read_flag_in,
    input  logic                   mem_write_flag_in,
    input  logic                   mem_sign_flag_in,
    input  logic [MEM_SEL_BUS-1:0] mem_sel_in,
    input  logic [DATA_W-1:0]      mem_write_data_in,
    input  logic [DATA_W-1:0]      result_in,
    input  logic                   reg_write_en_in,
    input  logic [4:0]             reg_write_addr_in,
    input  logic [DATA_W-1:0]      current_pc_addr_in,
    mem_stage_if.master            ram,
    output logic                   stall_request,
    output logic                   mem_load_flag,
    output logic [DATA_W-1:0]      result_out,
    output logic                   reg_write_en_out,
    output logic [4:0]             reg_write_addr_out,
    output logic [DATA_W-1:0]      current_pc_addr_out,
    output logic                   addr_error,
    output logic                   bus_error
);

    localparam int CNT_W = (RAM_TIMEOUT < 2) ? 1 : $clog2(RAM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_TIMEOUT - 1);

    mem_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [DATA_W-1:0]      addr_q, addr_d;
    logic [MEM_SEL_BUS-1:0] be_q, be_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      result_q, result_d;
    logic                   rwe_q, rwe_d;
    logic [4:0]             rwa_q, rwa_d;
    logic [DATA_W-1:0]      pc_q, pc_d;
    logic                   aerr_q, aerr_d;
    logic                   berr_q, berr_d;

    logic                   mem_op;
    logic                   misalign;
    logic                   load_wb;
    logic                   wb_en;
    logic                   use_load;
    logic [MEM_SEL_BUS-1:0] be_calc;
    logic [DATA_W-1:0]      wdata_calc;
    logic [DATA_W-1:0]      load_data;

    assign mem_op = mem_read_flag_in | mem_write_flag_in;

    mem_stage_align #(.DATA_W(DATA_W)) u_align (
        .sel_i        (mem_sel_in),
        .off_i        (result_in[1:0]),
        .sign_i       (mem_sign_flag_in),
        .store_data_i (mem_write_data_in),
        .rdata_i      (ram.ram_rdata),
        .be_o         (be_calc),
        .wdata_o      (wdata_calc),
        .load_data_o  (load_data),
        .misalign_o   (misalign)
    );

    // Next-state, RAM request and writeback-register decisions.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_pend_d  = flush_pend_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        result_d      = result_q;
        rwe_d         = rwe_q;
        rwa_d         = rwa_q;
        pc_d          = pc_q;
        aerr_d        = 1'b0;
        berr_d        = 1'b0;
        stall_request = 1'b0;
        load_wb       = 1'b0;
        wb_en         = 1'b0;
        use_load      = 1'b0;

        case (state_q)
            MEM_ST_IDLE: begin
                flush_pend_d = 1'b0;
                if (mem_op && !flush && !misalign) begin
                    // Launch the RAM access; WB sees a bubble while we wait.
                    stall_request = 1'b1;
                    state_d       = MEM_ST_WAIT;
                    req_d         = 1'b1;
                    we_d          = mem_write_flag_in;
                    addr_d        = {result_in[DATA_W-1:2], 2'b00};
                    be_d          = be_calc;
                    wdata_d       = wdata_calc;
                    cnt_d         = '0;
                    rwe_d         = 1'b0;
                end else begin
                    // Plain ALU op, flushed op, or misaligned access: retire immediately.
                    load_wb = 1'b1;
                    wb_en   = reg_write_en_in & ~flush & ~mem_op;
                    aerr_d  = mem_op & misalign & ~flush;
                end
            end
            MEM_ST_WAIT: begin
                if (flush) flush_pend_d = 1'b1;
                if (ram.ram_ack) begin
                    load_wb      = 1'b1;
                    use_load     = mem_read_flag_in;
                    wb_en        = reg_write_en_in & mem_read_flag_in & ~flush & ~flush_pend_q;
                    req_d        = 1'b0;
                    state_d      = MEM_ST_IDLE;
                    flush_pend_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    load_wb      = 1'b1;
                    wb_en        = 1'b0;
                    berr_d       = 1'b1;
                    req_d        = 1'b0;
                    state_d      = MEM_ST_IDLE;
                    flush_pend_d = 1'b0;
                end else begin
                    stall_request = 1'b1;
                    cnt_d         = cnt_q + CNT_W'(1);
                    rwe_d         = 1'b0;
                end
            end
            default: state_d = MEM_ST_IDLE;
        endcase

        if (load_wb) begin
            result_d = use_load ? load_data : result_in;
            rwe_d    = wb_en;
            rwa_d    = reg_write_addr_in;
            pc_d     = current_pc_addr_in;
        end
    end

    // State, RAM bus and MEM/WB registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MEM_ST_IDLE;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            result_q     <= '0;
            rwe_q        <= 1'b0;
            rwa_q        <= '0;
            pc_q         <= '0;
            aerr_q       <= 1'b0;
            berr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            result_q     <= result_d;
            rwe_q        <= rwe_d;
            rwa_q        <= rwa_d;
            pc_q         <= pc_d;
            aerr_q       <= aerr_d;
            berr_q       <= berr_d;
        end
    end

    assign ram.ram_req          = req_q;
    assign ram.ram_we           = we_q;
    assign ram.ram_addr         = addr_q;
    assign ram.ram_be           = be_q;
    assign ram.ram_wdata        = wdata_q;
    assign mem_load_flag        = mem_read_flag_in;
    assign result_out           = result_q;
    assign reg_write_en_out     = rwe_q;
    assign reg_write_addr_out   = rwa_q;
    assign current_pc_addr_out  = pc_q;
    assign addr_error           = aerr_q;
    assign bus_error            = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scripted RAM responder and a
// writeback scoreboard.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 8;

    typedef struct {
        logic [31:0] res;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] pc;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, rd, wr, sgn, rwe_in;
    logic [3:0]  sel;
    logic [31:0] wdat, res_in, pc_in;
    logic [4:0]  rwa_in;

    logic        stall_request, mem_load_flag, reg_write_en_out, addr_error, bus_error;
    logic [31:0] result_out, current_pc_addr_out;
    logic [4:0]  reg_write_addr_out;

    mem_stage_if #(.DATA_W(32)) ram_if ();

    mem_stage #(.DATA_W(32), .RAM_TIMEOUT(TO)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush               (flush),
        .mem_read_flag_in    (rd),
        .mem_write_flag_in   (wr),
        .mem_sign_flag_in    (sgn),
        .mem_sel_in          (sel),
        .mem_write_data_in   (wdat),
        .result_in           (res_in),
        .reg_write_en_in     (rwe_in),
        .reg_write_addr_in   (rwa_in),
        .current_pc_addr_in  (pc_in),
        .ram                 (ram_if.master),
        .stall_request       (stall_request),
        .mem_load_flag       (mem_load_flag),
        .result_out          (result_out),
        .reg_write_en_out    (reg_write_en_out),
        .reg_write_addr_out  (reg_write_addr_out),
        .current_pc_addr_out (current_pc_addr_out),
        .addr_error          (addr_error),
        .bus_error           (bus_error)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    wb_t         sb[$];
    logic        ram_en = 1'b0;
    logic        stray = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] rdata_val = '0;
    logic        cap_we, saw_req;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RAM responder: acks after ack_delay non-ack cycles of an outstanding request.
    task automatic ram_model();
        if (ram_if.ram_req && ram_en) begin
            if (wait_cnt == ack_delay) begin
                ram_if.ram_ack   = 1'b1;
                ram_if.ram_rdata = rdata_val;
                wait_cnt         = 0;
            end else begin
                ram_if.ram_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            ram_if.ram_ack = stray;
            wait_cnt       = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ram_model();
    endtask

    task automatic drive(input logic r, input logic w, input logic s, input logic [3:0] sl,
                         input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic [4:0] wa, input logic [31:0] pc);
        rd = r; wr = w; sgn = s; sel = sl; res_in = a; wdat = d;
        rwe_in = we; rwa_in = wa; pc_in = pc;
    endtask

    task automatic push(input logic [31:0] r, input logic w, input logic [4:0] wa,
                        input logic [31:0] pc);
        wb_t e;
        e.res = r; e.we = w; e.wa = wa; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, result_out, e.res);
            chk({tag, "_we"}, {31'd0, reg_write_en_out}, {31'd0, e.we});
            chk({tag, "_wa"}, {27'd0, reg_write_addr_out}, {27'd0, e.wa});
            chk({tag, "_pc"}, current_pc_addr_out, e.pc);
        end
    endtask

    // Run the driven instruction until WB loads, counting stall cycles, then score it.
    task automatic run_op(input string tag, input int exp_stall, input int flush_at);
        int stalls = 0;
        int cyc = 0;
        bit done = 0;
        saw_req = 1'b0;
        while (!done) begin
            flush = (cyc == flush_at);
            #1;
            if (stall_request) stalls++;
            if (ram_if.ram_req) begin
                saw_req   = 1'b1;
                cap_we    = ram_if.ram_we;
                cap_be    = ram_if.ram_be;
                cap_addr  = ram_if.ram_addr;
                cap_wdata = ram_if.ram_wdata;
            end
            if (!stall_request) done = 1;
            tick();
            cyc++;
            if (!done && cyc > 40) begin
                chk({tag, "_bound"}, 32'd1, 32'd0);
                done = 1;
            end
        end
        flush = 1'b0; rd = 1'b0; wr = 1'b0; rwe_in = 1'b0;
        chk({tag, "_stalls"}, stalls, exp_stall);
        check_wb(tag);
    endtask

    initial begin
        flush = 0;
        drive(0, 0, 0, 4'b0000, 32'h0, 32'h0, 0, 5'd0, 32'h0);
        ram_if.ram_ack   = 1'b0;
        ram_if.ram_rdata = '0;
        #3;
        chk("rst_result", result_out, 32'h0);
        chk("rst_we", {31'd0, reg_write_en_out}, 32'h0);
        chk("rst_pc", current_pc_addr_out, 32'h0);
        chk("rst_req", {31'd0, ram_if.ram_req}, 32'h0);
        chk("rst_aerr", {31'd0, addr_error}, 32'h0);
        chk("rst_berr", {31'd0, bus_error}, 32'h0);
        #9 rst_n = 1'b1;
        tick();

        // ALU op passes straight through with one-cycle latency
        drive(0, 0, 0, 4'b0000, 32'h1234, 32'h0, 1, 5'd5, 32'h100);
        push(32'h1234, 1, 5'd5, 32'h100);
        run_op("nop", 0, -1);
        chk("nop_noreq", {31'd0, saw_req}, 32'h0);

        // Signed byte load from the top lane, ack on the third WAIT cycle
        ram_en = 1; ack_delay = 2; rdata_val = 32'h80123456;
        drive(1, 0, 1, MEM_SEL_BYTE, 32'h1003, 32'h0, 1, 5'd7, 32'h104);
        push(32'hFFFF_FF80, 1, 5'd7, 32'h104);
        #1 chk("lb_loadflag", {31'd0, mem_load_flag}, 32'h1);
        run_op("lb", 3, -1);
        chk("lb_be", {28'd0, cap_be}, 32'h8);
        chk("lb_addr", cap_addr, 32'h1000);
        chk("lb_we", {31'd0, cap_we}, 32'h0);

        // Halfword store to the upper half
        ack_delay = 0;
        drive(0, 1, 0, MEM_SEL_HALF, 32'h2002, 32'h0000ABCD, 1, 5'd8, 32'h108);
        push(32'h2002, 0, 5'd8, 32'h108);
        run_op("sh", 1, -1);
        chk("sh_be", {28'd0, cap_be}, 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);
        chk("sh_we", {31'd0, cap_we}, 32'h1);
        chk("sh_addr", cap_addr, 32'h2000);

        // Misaligned word load
        drive(1, 0, 0, MEM_SEL_WORD, 32'h3001, 32'h0, 1, 5'd9, 32'h10C);
        push(32'h3001, 0, 5'd9, 32'h10C);
        run_op("lw_mis", 0, -1);
        chk("lw_mis_noreq", {31'd0, saw_req}, 32'h0);
        chk("lw_mis_aerr", {31'd0, addr_error}, 32'h1);
        tick();
        chk("lw_mis_aerr_pulse", {31'd0, addr_error}, 32'h0);

        // RAM never answers: timeout
        ram_en = 0;
        drive(1, 0, 0, MEM_SEL_WORD, 32'h4000, 32'h0, 1, 5'd10, 32'h110);
        push(32'h4000, 0, 5'd10, 32'h110);
        run_op("lw_to", TO, -1);
        chk("lw_to_berr", {31'd0, bus_error}, 32'h1);
        chk("lw_to_req", {31'd0, ram_if.ram_req}, 32'h0);
        tick();
        chk("lw_to_berr_pulse", {31'd0, bus_error}, 32'h0);

        // Stray ack while idle must be ignored
        stray = 1;
        tick();
        #1;
        chk("stray_stall", {31'd0, stall_request}, 32'h0);
        chk("stray_req", {31'd0, ram_if.ram_req}, 32'h0);
        stray = 0;

        // Zero-extended halfword load from the upper half
        ram_en = 1; ack_delay = 1; rdata_val = 32'hBEEF1234;
        drive(1, 0, 0, MEM_SEL_HALF, 32'h4002, 32'h0, 1, 5'd11, 32'h114);
        push(32'h0000BEEF, 1, 5'd11, 32'h114);
        run_op("lhu", 2, -1);
        chk("lhu_be", {28'd0, cap_be}, 32'hC);

        // Sign-extended halfword load from the lower half
        ack_delay = 0; rdata_val = 32'h00008001;
        drive(1, 0, 1, MEM_SEL_HALF, 32'h4800, 32'h0, 1, 5'd15, 32'h124);
        push(32'hFFFF8001, 1, 5'd15, 32'h124);
        run_op("lh", 1, -1);
        chk("lh_be", {28'd0, cap_be}, 32'h3);

        // Flush during WAIT: transaction completes, writeback suppressed
        ack_delay = 3; rdata_val = 32'hCAFEF00D;
        drive(1, 0, 0, MEM_SEL_WORD, 32'h5000, 32'h0, 1, 5'd12, 32'h118);
        push(32'hCAFEF00D, 0, 5'd12, 32'h118);
        run_op("lw_fl", 4, 1);
        drive(0, 0, 0, 4'b0000, 32'h55, 32'h0, 1, 5'd13, 32'h11C);
        push(32'h55, 1, 5'd13, 32'h11C);
        run_op("after_fl", 0, -1);

        // Reset in the middle of a WAIT
        ram_en = 0;
        drive(1, 0, 0, MEM_SEL_WORD, 32'h6000, 32'h0, 1, 5'd14, 32'h200);
        tick(); tick(); tick();
        chk("rstw_req_before", {31'd0, ram_if.ram_req}, 32'h1);
        drive(0, 0, 0, 4'b0000, 32'h77, 32'h0, 1, 5'd14, 32'h120);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_req", {31'd0, ram_if.ram_req}, 32'h0);
        chk("rstw_result", result_out, 32'h0);
        chk("rstw_we", {31'd0, reg_write_en_out}, 32'h0);
        chk("rstw_pc", current_pc_addr_out, 32'h0);
        rst_n = 1'b1;
        ram_en = 1; ack_delay = 0;
        tick();
        push(32'h77, 1, 5'd14, 32'h120);
        run_op("post_rst", 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
